// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the icache/dcache memory-port arbiter.
package mem_arb_types;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  typedef enum logic {
    ICACHE = 1'b0,
    DCACHE = 1'b1
  } grant_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } mem_op_t;

  // The requester that did not win last time.
  function automatic grant_t other_side(grant_t g);
    return (g == ICACHE) ? DCACHE : ICACHE;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_grant_select.sv
// Round-robin grant policy between icache and dcache. Kept separate so a
// fixed-priority policy can be dropped in without touching the FSM.
module arb_grant_select
  import mem_arb_types::*;
(
  input  logic   i_req,
  input  logic   d_req,
  input  grant_t last_grant,
  output logic   grant_valid,
  output grant_t grant
);

  // Contention goes to the side opposite the previous winner.
  always_comb begin
    grant_valid = i_req | d_req;
    grant       = ICACHE;
    if (i_req && d_req) grant = other_side(last_grant);
    else if (d_req)     grant = DCACHE;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single physical-memory port between icache and dcache misses.
// Request fields are captured at grant so the downstream port stays stable
// for the whole transaction; a RELEASE cycle after each completion lets the
// requester drop its request before the next arbitration.
module mem_port_arbiter
  import mem_arb_types::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic                  i_resp,
  output logic [LINE_WIDTH-1:0] i_rdata,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic                  d_resp,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp,
  output logic                  busy
);

  arb_state_t            state, state_nxt;
  grant_t                last_grant;
  mem_op_t               op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] wdata_q;

  logic   d_req;
  logic   grant_valid;
  grant_t grant;
  logic   serving;
  logic   take_grant;

  assign d_req      = d_read | d_write;
  assign take_grant = (state == IDLE) && grant_valid;

  arb_grant_select u_grant_select (
    .i_req       (i_read),
    .d_req       (d_req),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  // Next-state: serve until the memory completes, then one release cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_valid) state_nxt = (grant == DCACHE) ? SERVE_D : SERVE_I;
      SERVE_I: if (pmem_resp) state_nxt = RELEASE;
      SERVE_D: if (pmem_resp) state_nxt = RELEASE;
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, round-robin history and the request captured at grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= ICACHE;
      op_q       <= OP_READ;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state <= state_nxt;
      if (take_grant) begin
        last_grant <= grant;
        if (grant == DCACHE) begin
          addr_q  <= d_address;
          wdata_q <= d_wdata;
          // write wins if both d_read and d_write are (illegally) high
          op_q    <= d_write ? OP_WRITE : OP_READ;
        end else begin
          addr_q  <= i_address;
          wdata_q <= '0;
          op_q    <= OP_READ;
        end
      end
    end
  end

  // Downstream port is driven only while serving; zero in IDLE/RELEASE.
  always_comb begin
    serving      = (state == SERVE_I) || (state == SERVE_D);
    pmem_read    = serving && (op_q == OP_READ);
    pmem_write   = serving && (op_q == OP_WRITE);
    pmem_address = serving ? addr_q  : '0;
    pmem_wdata   = serving ? wdata_q : '0;
    i_resp       = (state == SERVE_I) && pmem_resp;
    d_resp       = (state == SERVE_D) && pmem_resp;
    i_rdata      = pmem_rdata;
    d_rdata      = pmem_rdata;
    busy         = (state != IDLE);
  end

  // Protocol checks: illegal dcache request pair and read/write exclusivity.
  always @(posedge clk) begin
    if (rst) begin
      assert (!(d_read && d_write))
        else $warning("mem_port_arbiter: d_read and d_write both high, write takes precedence");
      assert (!(pmem_read && pmem_write))
        else $error("mem_port_arbiter: pmem_read and pmem_write both high");
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter. The reference model
// tracks only which side is pending and who won last, and predicts the
// grant, the downstream op and the resp routing from those.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read;
  logic [AW-1:0] i_address;
  logic          i_resp;
  logic [LW-1:0] i_rdata;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_address;
  logic [LW-1:0] d_wdata;
  logic          d_resp;
  logic [LW-1:0] d_rdata;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;
  logic          busy;

  int n_checks = 0;
  int n_pass   = 0;
  int last_side;  // model: 0 = icache won last, 1 = dcache won last

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_resp(i_resp), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_resp(d_resp), .d_rdata(d_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .busy(busy)
  );

  function automatic int pick_side(bit i_pend, bit d_pend, int last);
    if (i_pend && d_pend) return 1 - last;
    return d_pend ? 1 : 0;
  endfunction

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] r;
    for (int k = 0; k < LW / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic clear_inputs();
    i_read = 0; d_read = 0; d_write = 0;
    i_address = '0; d_address = '0; d_wdata = '0;
    pmem_rdata = '0; pmem_resp = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    last_side = 0;
  endtask

  // Advance negedges until a downstream op is visible (bounded).
  task automatic wait_op(output int cyc, output bit seen);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(pmem_read || pmem_write) && cyc < 20);
    seen = pmem_read || pmem_write;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    i_read = 1; i_address = 32'h1000;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({pmem_read, pmem_write, i_resp, d_resp, busy} !== 5'b0)
      $display("FAIL reset_ctrl: got %b want 00000", {pmem_read, pmem_write, i_resp, d_resp, busy});
    else n_pass++;
    n_checks++;
    if (pmem_address !== '0 || pmem_wdata !== '0)
      $display("FAIL reset_data: got addr %h wdata %h want 0", pmem_address, pmem_wdata);
    else n_pass++;
    i_read = 0;
    rst = 1'b1;
    last_side = 0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_idle_busy: got %b want 0", busy);
    else n_pass++;
  endtask

  task automatic test_single_i();
    logic [LW-1:0] a5;
    do_reset();
    i_read = 1; i_address = 32'h0000_1000;
    @(negedge clk);
    n_checks++;
    if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_address !== 32'h1000)
      $display("FAIL single_i_op: got rd %b wr %b addr %h want 1 0 00001000", pmem_read, pmem_write, pmem_address);
    else n_pass++;
    a5 = {32{8'hA5}};
    pmem_rdata = a5; pmem_resp = 1;
    #1;
    n_checks++;
    if (i_resp !== 1'b1 || d_resp !== 1'b0 || i_rdata !== a5)
      $display("FAIL single_i_resp: got i %b d %b rdata %h want 1 0 %h", i_resp, d_resp, i_rdata, a5);
    else n_pass++;
    @(negedge clk);
    pmem_resp = 0; i_read = 0;
    n_checks++;
    if (busy !== 1'b1 || pmem_read !== 1'b0 || i_resp !== 1'b0)
      $display("FAIL single_i_release: got busy %b rd %b resp %b want 1 0 0", busy, pmem_read, i_resp);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL single_i_idle: got busy %b want 0", busy);
    else n_pass++;
  endtask

  task automatic test_contention();
    logic [LW-1:0] wd;
    do_reset();
    wd = rand_line();
    i_read = 1; i_address = 32'h1000;
    d_write = 1; d_address = 32'h2000; d_wdata = wd;
    @(negedge clk);
    n_checks++;
    if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_address !== 32'h2000 || pmem_wdata !== wd)
      $display("FAIL contention_first_d: got wr %b rd %b addr %h want 1 0 00002000", pmem_write, pmem_read, pmem_address);
    else n_pass++;
    pmem_resp = 1;
    #1;
    n_checks++;
    if (d_resp !== 1'b1 || i_resp !== 1'b0)
      $display("FAIL contention_d_resp: got d %b i %b want 1 0", d_resp, i_resp);
    else n_pass++;
    @(negedge clk);
    pmem_resp = 0; d_write = 0;
    n_checks++;
    if (busy !== 1'b1 || pmem_read !== 1'b0 || pmem_write !== 1'b0)
      $display("FAIL contention_release: got busy %b rd %b wr %b want 1 0 0", busy, pmem_read, pmem_write);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL contention_idle: got busy %b want 0", busy);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (pmem_read !== 1'b1 || pmem_address !== 32'h1000)
      $display("FAIL contention_then_i: got rd %b addr %h want 1 00001000", pmem_read, pmem_address);
    else n_pass++;
    pmem_resp = 1;
    #1;
    n_checks++;
    if (i_resp !== 1'b1 || d_resp !== 1'b0)
      $display("FAIL contention_i_resp: got i %b d %b want 1 0", i_resp, d_resp);
    else n_pass++;
    @(negedge clk);
    pmem_resp = 0; i_read = 0;
    @(negedge clk);
  endtask

  task automatic test_alternation();
    int cyc, side;
    bit seen;
    do_reset();
    i_read = 1; i_address = 32'h0000_1000;
    d_read = 1; d_address = 32'h0000_2000;
    for (int k = 0; k < 6; k++) begin
      wait_op(cyc, seen);
      n_checks++;
      if (!seen) begin
        $display("FAIL alt_timeout: txn %0d got no op want op within 20 cycles", k);
        break;
      end else n_pass++;
      if (k > 0) begin
        n_checks++;
        if (cyc !== 2) $display("FAIL alt_turnaround: txn %0d got %0d idle cycles want 2", k, cyc);
        else n_pass++;
      end
      side = pick_side(1'b1, 1'b1, last_side);
      n_checks++;
      if (pmem_address !== (side ? 32'h2000 : 32'h1000) || pmem_read !== 1'b1)
        $display("FAIL alt_grant: txn %0d got addr %h rd %b want side %0d", k, pmem_address, pmem_read, side);
      else n_pass++;
      repeat (2) @(negedge clk);
      pmem_resp = 1;
      #1;
      n_checks++;
      if ({i_resp, d_resp} !== (side ? 2'b01 : 2'b10))
        $display("FAIL alt_resp: txn %0d got i %b d %b want side %0d", k, i_resp, d_resp, side);
      else n_pass++;
      @(negedge clk);
      pmem_resp = 0;
      last_side = side;
    end
    i_read = 0; d_read = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_hold();
    logic [LW-1:0] wd;
    int cyc;
    bit seen, held;
    do_reset();
    wd = rand_line();
    d_write = 1; d_address = 32'h2000; d_wdata = wd;
    wait_op(cyc, seen);
    d_address = 32'h3000; d_write = 0; d_wdata = ~wd;
    held = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (pmem_write !== 1'b1 || pmem_address !== 32'h2000 || pmem_wdata !== wd) held = 0;
    end
    n_checks++;
    if (!held) $display("FAIL hold_latched: got wr %b addr %h want 1 00002000", pmem_write, pmem_address);
    else n_pass++;
    pmem_resp = 1;
    #1;
    n_checks++;
    if (d_resp !== 1'b1 || pmem_write !== 1'b1)
      $display("FAIL hold_resp: got d_resp %b wr %b want 1 1", d_resp, pmem_write);
    else n_pass++;
    @(negedge clk);
    pmem_resp = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit seen;
    do_reset();
    i_read = 1; i_address = 32'h1000;
    wait_op(cyc, seen);
    @(negedge clk);
    rst = 1'b0; i_read = 0;
    #1;
    n_checks++;
    if ({pmem_read, pmem_write, i_resp, d_resp, busy} !== 5'b0 || pmem_address !== '0)
      $display("FAIL reset_mid_outputs: got %b addr %h want 00000 0", {pmem_read, pmem_write, i_resp, d_resp, busy}, pmem_address);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    last_side = 0;
    pmem_resp = 1;
    #1;
    n_checks++;
    if (i_resp !== 1'b0 || d_resp !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset_mid_stale_resp: got i %b d %b busy %b want 0 0 0", i_resp, d_resp, busy);
    else n_pass++;
    @(negedge clk);
    pmem_resp = 0;
    n_checks++;
    if (busy !== 1'b0 || pmem_read !== 1'b0) $display("FAIL reset_mid_idle: got busy %b rd %b want 0 0", busy, pmem_read);
    else n_pass++;
    i_read = 1; i_address = 32'h1000;
    d_read = 1; d_address = 32'h2000;
    wait_op(cyc, seen);
    n_checks++;
    if (pmem_address !== (pick_side(1'b1, 1'b1, last_side) ? 32'h2000 : 32'h1000))
      $display("FAIL reset_mid_rr: got addr %h want dcache 00002000", pmem_address);
    else n_pass++;
    pmem_resp = 1;
    @(negedge clk);
    pmem_resp = 0; i_read = 0; d_read = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_write_precedence();
    int cyc;
    bit seen;
    do_reset();
    d_read = 1; d_write = 1; d_address = 32'h4000; d_wdata = rand_line();
    wait_op(cyc, seen);
    d_read = 0;
    n_checks++;
    if (pmem_write !== 1'b1 || pmem_read !== 1'b0)
      $display("FAIL write_precedence: got wr %b rd %b want 1 0", pmem_write, pmem_read);
    else n_pass++;
    pmem_resp = 1;
    @(negedge clk);
    pmem_resp = 0; d_write = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    do_reset();
    for (int r = 0; r < 40; r++) begin
      bit ip, dp, dw;
      logic [AW-1:0] ia, da;
      logic [LW-1:0] wd;
      ip = 1'($urandom_range(0, 1));
      dp = 1'($urandom_range(0, 1));
      if (!ip && !dp) begin
        if (r % 2 == 0) ip = 1; else dp = 1;
      end
      dw = 1'($urandom_range(0, 1));
      ia = $urandom; da = $urandom; wd = rand_line();
      i_read = ip; i_address = ia;
      d_read = dp && !dw; d_write = dp && dw; d_address = da; d_wdata = wd;
      while (ip || dp) begin
        int side, cyc, lat;
        bit seen, exp_wr;
        logic [LW-1:0] rd;
        wait_op(cyc, seen);
        n_checks++;
        if (!seen) begin
          $display("FAIL rand_timeout: round %0d got no op want op within 20 cycles", r);
          ip = 0; dp = 0; i_read = 0; d_read = 0; d_write = 0;
        end else begin
          n_pass++;
          side = pick_side(ip, dp, last_side);
          exp_wr = (side == 1) && dw;
          n_checks++;
          if ({pmem_read, pmem_write} !== (exp_wr ? 2'b01 : 2'b10) || pmem_address !== (side ? da : ia))
            $display("FAIL rand_op: round %0d got rd %b wr %b addr %h want side %0d wr %b addr %h",
                     r, pmem_read, pmem_write, pmem_address, side, exp_wr, side ? da : ia);
          else n_pass++;
          if (exp_wr) begin
            n_checks++;
            if (pmem_wdata !== wd) $display("FAIL rand_wdata: round %0d got %h want %h", r, pmem_wdata, wd);
            else n_pass++;
          end
          lat = $urandom_range(1, 4);
          rd = rand_line();
          repeat (lat - 1) @(negedge clk);
          pmem_rdata = rd; pmem_resp = 1;
          #1;
          n_checks++;
          if ({i_resp, d_resp} !== (side ? 2'b01 : 2'b10) || (side ? d_rdata : i_rdata) !== rd)
            $display("FAIL rand_resp: round %0d got i %b d %b want side %0d", r, i_resp, d_resp, side);
          else n_pass++;
          @(negedge clk);
          pmem_resp = 0;
          last_side = side;
          if (side == 1) begin dp = 0; d_read = 0; d_write = 0; end
          else begin ip = 0; i_read = 0; end
        end
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_single_i();
    test_contention();
    test_alternation();
    test_hold();
    test_reset_mid();
    test_write_precedence();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single physical-memory (cacheline adaptor) port between the instruction cache and the data cache on a miss.
- Sits between the two caches' line-fill/write-back interfaces and main memory, below the pipelined datapath.
- Grants one requester at a time. Round-robin is used under contention. Requests and data are latched at grant, so the downstream port is stable for the whole transaction.

Parameters:
- ADDR_WIDTH, 32, width of line address.
- LINE_WIDTH, 256, cacheline width in bits.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- i_read  input  1  icache line-fill request
- i_address  input  ADDR_WIDTH  icache line address
- i_resp  output  1  icache transaction complete, 1-cycle pulse
- i_rdata  output  LINE_WIDTH  line returned to icache
- d_read  input  1  dcache line-fill request
- d_write  input  1  dcache write-back request
- d_address  input  ADDR_WIDTH  dcache line address
- d_wdata  input  LINE_WIDTH  dcache write-back line
- d_resp  output  1  dcache transaction complete, 1-cycle pulse
- d_rdata  output  LINE_WIDTH  line returned to dcache
- pmem_read  output  1  downstream read
- pmem_write  output  1  downstream write
- pmem_address  output  ADDR_WIDTH  downstream address
- pmem_wdata  output  LINE_WIDTH  downstream write line
- pmem_rdata  input  LINE_WIDTH  downstream read line
- pmem_resp  input  1  downstream done, 1-cycle pulse
- busy  output  1  transaction in flight (perf counter / debug)

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, last_grant=ICACHE.
  - All outputs 0: pmem_read, pmem_write, i_resp, d_resp, busy, pmem_address, pmem_wdata.
  - Reset mid-transaction abandons it. No resp is issued. A pmem_resp arriving later in IDLE is ignored.
- States: IDLE, SERVE_I, SERVE_D, RELEASE.
- IDLE:
  - Samples requests. d_req = d_read | d_write.
  - Only i_read -> SERVE_I. Only d_req -> SERVE_D.
  - Both -> grant the side opposite last_grant, so the first contention after reset goes to dcache.
  - Neither -> stay in IDLE.
  - On the transition, latch into registers: address, wdata, and op (write if d_write, else read). last_grant updates to the granted side.
- SERVE_I / SERVE_D:
  - pmem_read/pmem_write driven from the latched op; pmem_address/pmem_wdata from the latched registers; busy=1.
  - Requester input changes are ignored while serving.
  - Holds until pmem_resp=1. In that cycle, the granted side's resp=1 (combinational from pmem_resp) and its rdata=pmem_rdata. Next state RELEASE.
- RELEASE:
  - One cycle. All pmem and resp outputs 0, busy=1.
  - Gives the requester a cycle to drop its request, so a stale request is never re-granted. Next state IDLE.
- Latency:
  - Request seen in IDLE at cycle n -> pmem op asserted at n+1.
  - Resp in the same cycle as pmem_resp.
  - Minimum request-to-request turnaround: 2 idle cycles (RELEASE, IDLE).
- i_rdata/d_rdata always mirror pmem_rdata. They are valid only with the matching resp.
- d_read and d_write both high is illegal:
  - Write takes precedence.
  - Simulation assertion fires.
- pmem_read and pmem_write are never both 1. Assert this.
- At most one of i_resp/d_resp is high per cycle. A resp pulse never occurs without pmem_resp.
- Starvation bound: under continuous contention, grants strictly alternate I,D,I,D.

Decomposition:
- Package mem_arb_types:
  - arb_state_t enum (IDLE, SERVE_I, SERVE_D, RELEASE).
  - grant_t enum (ICACHE, DCACHE).
  - mem_op_t enum (OP_READ, OP_WRITE).
- Sub-module arb_grant_select (combinational): inputs i_req, d_req, last_grant; outputs grant_valid, grant.
  - Isolates the round-robin policy so it can be swapped for fixed priority.
- FSM and latch registers live in mem_port_arbiter.

Test Plan:
- Reset release, i_read=1, i_address=0x0000_1000.
  - Expect pmem_read=1 and pmem_address=0x1000 one cycle later.
  - pmem_resp with pmem_rdata=256'hA5.. -> i_resp=1 and i_rdata=A5.. in the same cycle, d_resp=0.
- i_read and d_write asserted together right after reset, d_address=0x2000.
  - Dcache is granted first: pmem_write=1, pmem_wdata=d_wdata.
  - After d_resp, RELEASE, IDLE, then SERVE_I with pmem_address=0x1000.
- Continuous i_read and d_read with pmem_resp returned 3 cycles after each op.
  - 6 transactions are granted D,I,D,I,D,I.
  - Each turnaround is exactly 2 cycles.
- During SERVE_D, change d_address 0x2000->0x3000 and deassert d_write.
  - pmem_address stays 0x2000 and pmem_write stays 1 until pmem_resp.
- Drive rst low 2 cycles into SERVE_I, then release; pulse pmem_resp in IDLE.
  - No i_resp, outputs all 0, state IDLE.
  - Next contention grants dcache.
- Assert d_read and d_write together -> assertion fires and pmem_write=1 (write precedence).
